// File: rtl/vid_line_fetcher.sv
// Video line-fetch engine: incremental DDR2 line addressing, ping-pong line buffer, RGB888/GRAY8 unpack.
// Optional feature macro VLF_INVERT_EN: valid pixel channels are output inverted (8'hFF - c).
module vid_line_fetcher #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int MODE       = 0,
  parameter int NUM_FB     = 1,
  parameter int BASE_ADDR  = 0,
  parameter int FB_STRIDE  = 2097152,
  parameter int LINE_BYTES = 2560
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_req,
  input  logic [10:0] line_vpos,
  input  logic [1:0]  frame_sel,
  output logic        disp_start,
  output logic [29:0] disp_addr,
  input  logic        disp_busy,
  input  logic        disp_we,
  input  logic [9:0]  disp_waddr,
  input  logic [31:0] disp_wdata,
  input  logic [10:0] pix_hpos,
  output logic [23:0] pix_out,
  output logic        line_valid,
  output logic        overrun,
  output logic        desync,
  input  logic        ovr_clr
);

  localparam int PPW   = (MODE == 0) ? 1 : 4;
  localparam int WORDS = H_RES / PPW;
  localparam int AW    = $clog2(2 * WORDS);

  localparam logic [10:0] H_RES_V  = 11'(H_RES);
  localparam logic [10:0] V_RES_V  = 11'(V_RES);
  localparam logic [9:0]  WORDS_V  = 10'(WORDS);
  localparam logic [AW-1:0] BANK1_OFS = AW'(WORDS);
  localparam logic [1:0]  FB_MAX   = 2'(NUM_FB - 1);
  localparam logic [29:0] LINE_INC = 30'(LINE_BYTES);
  localparam logic [29:0] FB_BASE0 = 30'(BASE_ADDR);
  localparam logic [29:0] FB_BASE1 = 30'(BASE_ADDR + FB_STRIDE);
  localparam logic [29:0] FB_BASE2 = 30'(BASE_ADDR + 2 * FB_STRIDE);
  localparam logic [29:0] FB_BASE3 = 30'(BASE_ADDR + 3 * FB_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_disp_start;
  logic [29:0]   r_disp_addr;
  logic [29:0]   r_line_addr;
  logic [10:0]   r_exp_vpos;
  logic          r_desync;
  logic          r_overrun;
  logic          r_line_valid;
  logic          r_front;
  logic [1:0]    r_bank_valid;
  logic          r_fbank;
  logic          r_dropped;

  logic [31:0]   r_mem [0:2*WORDS-1];
  logic [31:0]   r_rd_word;
  logic [1:0]    r_bsel;
  logic          r_blank;
  logic [23:0]   r_pix;

  logic [1:0]    w_fb;
  logic [29:0]   w_fb_base;
  logic [29:0]   w_next_addr;
  logic          w_vpos_zero;
  logic          w_in_seq;
  logic          w_accept;
  logic          w_fetching;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [10:0]   w_hword;
  logic          w_hpos_ok;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_rd_addr;
  logic [7:0]    w_gray;
  logic [23:0]   w_pix;
  logic [23:0]   w_pix_fmt;

  assign disp_start = r_disp_start;
  assign disp_addr  = r_disp_addr;
  assign line_valid = r_line_valid;
  assign overrun    = r_overrun;
  assign desync     = r_desync;
  assign pix_out    = r_pix;

  // Next line address and request acceptance; frame base comes from a constant table
  always_comb begin
    if (frame_sel > FB_MAX) begin
      w_fb = FB_MAX;
    end else begin
      w_fb = frame_sel;
    end
    case (w_fb)
      2'd0:    w_fb_base = FB_BASE0;
      2'd1:    w_fb_base = FB_BASE1;
      2'd2:    w_fb_base = FB_BASE2;
      2'd3:    w_fb_base = FB_BASE3;
      default: w_fb_base = FB_BASE0;
    endcase
    w_vpos_zero = (line_vpos == 11'd0);
    if (w_vpos_zero) begin
      w_next_addr = w_fb_base;
    end else begin
      w_next_addr = r_line_addr + LINE_INC;
    end
    w_in_seq = w_vpos_zero || (!r_desync && (line_vpos == r_exp_vpos));
    w_accept = line_req && (r_state == S_IDLE) && w_in_seq && (line_vpos < V_RES_V);
  end

  // Control FSM, bank bookkeeping and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_disp_start <= 1'b0;
      r_disp_addr  <= 30'd0;
      r_line_addr  <= FB_BASE0;
      r_exp_vpos   <= 11'd0;
      r_desync     <= 1'b1;
      r_overrun    <= 1'b0;
      r_line_valid <= 1'b0;
      r_front      <= 1'b0;
      r_bank_valid <= 2'b00;
      r_fbank      <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      r_disp_start <= 1'b0;
      if (line_req) begin
        r_line_addr <= w_next_addr;
        r_exp_vpos  <= line_vpos + 11'd1;
        if (w_vpos_zero) begin
          r_desync <= 1'b0;
        end else if (line_vpos != r_exp_vpos) begin
          r_desync <= 1'b1;
        end
        r_front               <= ~r_front;
        r_line_valid          <= r_bank_valid[~r_front];
        r_bank_valid[r_front] <= 1'b0;
      end
      // A request that collides with a fetch wins over a same-cycle clear
      if (line_req && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_ISSUE;
            r_disp_start <= 1'b1;
            r_disp_addr  <= w_next_addr;
            r_fbank      <= r_front;
            r_dropped    <= 1'b0;
          end
        end
        S_ISSUE: r_state <= S_WAIT_HI;
        S_WAIT_HI: begin
          if (disp_busy) begin
            r_state <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!disp_busy) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state               <= S_IDLE;
          r_bank_valid[r_fbank] <= !(r_dropped || line_req);
        end
        default: r_state <= S_IDLE;
      endcase
      if (line_req && (r_state != S_IDLE)) begin
        r_dropped <= 1'b1;
      end
    end
  end

  // Write and read addressing into the two-bank line buffer
  always_comb begin
    w_fetching = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);
    w_wr_en    = disp_we && w_fetching && (disp_waddr < WORDS_V);
    if (r_fbank) begin
      w_wr_addr = AW'(disp_waddr) + BANK1_OFS;
    end else begin
      w_wr_addr = AW'(disp_waddr);
    end
    if (MODE == 0) begin
      w_hword = pix_hpos;
    end else begin
      w_hword = {2'b00, pix_hpos[10:2]};
    end
    w_hpos_ok = (pix_hpos < H_RES_V);
    if (w_hpos_ok) begin
      w_rd_idx = AW'(w_hword);
    end else begin
      w_rd_idx = {AW{1'b0}};
    end
    if (r_front) begin
      w_rd_addr = w_rd_idx + BANK1_OFS;
    end else begin
      w_rd_addr = w_rd_idx;
    end
  end

  // Line buffer RAM: write port from dispatcher, registered read port for display
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= disp_wdata;
    end
    r_rd_word <= r_mem[w_rd_addr];
  end

  // Unpack the fetched word into a 24-bit pixel
  always_comb begin
    case (r_bsel)
      2'd0:    w_gray = r_rd_word[7:0];
      2'd1:    w_gray = r_rd_word[15:8];
      2'd2:    w_gray = r_rd_word[23:16];
      2'd3:    w_gray = r_rd_word[31:24];
      default: w_gray = 8'h00;
    endcase
    if (MODE == 0) begin
      w_pix = r_rd_word[23:0];
    end else begin
      w_pix = {w_gray, w_gray, w_gray};
    end
`ifdef VLF_INVERT_EN
    w_pix_fmt = {8'hFF - w_pix[23:16], 8'hFF - w_pix[15:8], 8'hFF - w_pix[7:0]};
`else
    w_pix_fmt = w_pix;
`endif
  end

  // Two-stage read pipeline: byte select/blank, then formatted pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bsel  <= 2'd0;
      r_blank <= 1'b1;
      r_pix   <= 24'd0;
    end else begin
      r_bsel  <= pix_hpos[1:0];
      r_blank <= !w_hpos_ok || !r_line_valid;
      if (r_blank) begin
        r_pix <= 24'd0;
      end else begin
        r_pix <= w_pix_fmt;
      end
    end
  end

endmodule

// File: tb/tb_vid_line_fetcher.sv
// Randomized bench for vid_line_fetcher: RGB888 and GRAY8 instances against a line-level reference model.
module tb_vid_line_fetcher;

  localparam int H_RES      = 640;
  localparam int V_RES      = 8;
  localparam int NUM_FB     = 2;
  localparam int BASE_ADDR  = 0;
  localparam int FB_STRIDE  = 2097152;
  localparam int LINE_BYTES = 2560;

  logic        clk = 1'b0;
  logic        reset, line_req, disp_busy, disp_we, ovr_clr;
  logic [10:0] line_vpos, pix_hpos;
  logic [1:0]  frame_sel;
  logic [9:0]  disp_waddr;
  logic [31:0] disp_wdata;
  logic        disp_start_a, line_valid_a, overrun_a, desync_a;
  logic        disp_start_b, line_valid_b, overrun_b, desync_b;
  logic [29:0] disp_addr_a, disp_addr_b;
  logic [23:0] pix_a, pix_b;

  vid_line_fetcher #(.H_RES(H_RES), .V_RES(V_RES), .MODE(0), .NUM_FB(NUM_FB),
    .BASE_ADDR(BASE_ADDR), .FB_STRIDE(FB_STRIDE), .LINE_BYTES(LINE_BYTES)) u_dut_rgb (
    .clk(clk), .reset(reset), .line_req(line_req), .line_vpos(line_vpos), .frame_sel(frame_sel),
    .disp_start(disp_start_a), .disp_addr(disp_addr_a), .disp_busy(disp_busy), .disp_we(disp_we),
    .disp_waddr(disp_waddr), .disp_wdata(disp_wdata), .pix_hpos(pix_hpos), .pix_out(pix_a),
    .line_valid(line_valid_a), .overrun(overrun_a), .desync(desync_a), .ovr_clr(ovr_clr));

  vid_line_fetcher #(.H_RES(H_RES), .V_RES(V_RES), .MODE(1), .NUM_FB(NUM_FB),
    .BASE_ADDR(BASE_ADDR), .FB_STRIDE(FB_STRIDE), .LINE_BYTES(LINE_BYTES)) u_dut_gray (
    .clk(clk), .reset(reset), .line_req(line_req), .line_vpos(line_vpos), .frame_sel(frame_sel),
    .disp_start(disp_start_b), .disp_addr(disp_addr_b), .disp_busy(disp_busy), .disp_we(disp_we),
    .disp_waddr(disp_waddr), .disp_wdata(disp_wdata), .pix_hpos(pix_hpos), .pix_out(pix_b),
    .line_valid(line_valid_b), .overrun(overrun_b), .desync(desync_b), .ovr_clr(ovr_clr));

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  int n_start_a = 0;
  int n_start_b = 0;

  always @(posedge clk) begin
    if (disp_start_a) n_start_a++;
    if (disp_start_b) n_start_b++;
  end

  // Reference model: whole-line contents and flags, per the line-level rules
  logic [31:0] m_front [H_RES];
  logic [31:0] m_back  [H_RES];
  logic [31:0] m_wr    [H_RES];
  bit          m_front_valid, m_back_valid, m_desync, m_overrun, m_fetching, m_drop;
  int          m_exp;
  logic [29:0] m_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] chan_fix(input logic [23:0] p);
`ifdef VLF_INVERT_EN
    return {8'hFF - p[23:16], 8'hFF - p[15:8], 8'hFF - p[7:0]};
`else
    return p;
`endif
  endfunction

  function automatic logic [23:0] exp_rgb(input int h);
    if (!m_front_valid || h >= H_RES) return 24'd0;
    return chan_fix(m_front[h][23:0]);
  endfunction

  function automatic logic [23:0] exp_gray(input int h);
    logic [31:0] w;
    logic [7:0]  g;
    if (!m_front_valid || h >= H_RES) return 24'd0;
    w = m_front[h / 4];
    g = w[(h % 4) * 8 +: 8];
    return chan_fix({g, g, g});
  endfunction

  function automatic void model_reset();
    m_front_valid = 1'b0; m_back_valid = 1'b0; m_desync = 1'b1; m_overrun = 1'b0;
    m_fetching = 1'b0; m_drop = 1'b0; m_exp = 0; m_addr = 30'(BASE_ADDR);
  endfunction

  function automatic bit model_req(input int v, input int fs);
    int fb;
    bit acc;
    if (v == 0) begin
      fb = (fs >= NUM_FB) ? NUM_FB - 1 : fs;
      m_addr = 30'(BASE_ADDR + fb * FB_STRIDE);
      m_desync = 1'b0;
    end else begin
      m_addr = m_addr + 30'(LINE_BYTES);
      if (v != m_exp) m_desync = 1'b1;
    end
    m_exp = v + 1;
    acc = !m_fetching && !m_desync && (v < V_RES);
    if (m_fetching) begin
      m_overrun = 1'b1;
      m_drop = 1'b1;
    end
    m_front = m_back;
    m_front_valid = m_back_valid;
    m_back_valid = 1'b0;
    return acc;
  endfunction

  task automatic do_reset();
    reset = 1'b1; line_req = 1'b0; disp_busy = 1'b0; disp_we = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check_eq("rst_start_a", disp_start_a, 1'b0);
    check_eq("rst_start_b", disp_start_b, 1'b0);
    check_eq("rst_addr", disp_addr_a, 30'd0);
    check_eq("rst_pix", pix_a, 24'd0);
    check_eq("rst_lvalid", line_valid_a, 1'b0);
    check_eq("rst_ovr", overrun_a, 1'b0);
    check_eq("rst_desync_a", desync_a, m_desync);
    check_eq("rst_desync_b", desync_b, m_desync);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_req(input int v, input int fs, input bit clr, output bit acc);
    line_req = 1'b1; line_vpos = 11'(v); frame_sel = 2'(fs); ovr_clr = clr;
    @(negedge clk);
    line_req = 1'b0; ovr_clr = 1'b0;
    acc = model_req(v, fs);
    if (clr && !m_fetching) m_overrun = 1'b0;
    check_eq("lvalid_a", line_valid_a, m_front_valid);
    check_eq("lvalid_b", line_valid_b, m_front_valid);
    check_eq("desync_a", desync_a, m_desync);
    check_eq("desync_b", desync_b, m_desync);
    check_eq("overrun_a", overrun_a, m_overrun);
    check_eq("overrun_b", overrun_b, m_overrun);
  endtask

  task automatic wait_start();
    int k = 0;
    while (disp_start_a !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("start_seen_a", disp_start_a, 1'b1);
    check_eq("start_seen_b", disp_start_b, 1'b1);
    check_eq("addr_a", disp_addr_a, m_addr);
    check_eq("addr_b", disp_addr_b, m_addr);
  endtask

  task automatic do_fetch(input bit ovr, input int ovr_v, input int ovr_fs);
    bit dummy;
    logic [31:0] d;
    wait_start();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      disp_we = 1'b1; disp_waddr = 10'(H_RES + g); disp_wdata = $urandom;
      @(negedge clk);
    end
    disp_busy = 1'b1;
    for (int i = 0; i < H_RES; i++) begin
      d = $urandom;
      disp_we = 1'b1; disp_waddr = 10'(i); disp_wdata = d; m_wr[i] = d;
      if (ovr && i == 300) do_req(ovr_v, ovr_fs, 1'b1, dummy);
      else @(negedge clk);
    end
    disp_we = 1'b0; disp_busy = 1'b0;
    repeat (3) @(negedge clk);
    if (!m_drop) begin
      m_back = m_wr;
      m_back_valid = 1'b1;
    end
    m_fetching = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic check_line();
    int hl[12];
    hl = '{0, 1, 2, 3, 4, 5, H_RES - 1, H_RES, 2047, 0, 0, 0};
    for (int j = 9; j < 12; j++) hl[j] = $urandom_range(0, H_RES - 1);
    for (int j = 0; j < 12; j++) begin
      pix_hpos = 11'(hl[j]);
      @(negedge clk);
      @(negedge clk);
      check_eq($sformatf("pix_rgb[%0d]", hl[j]), pix_a, exp_rgb(hl[j]));
      check_eq($sformatf("pix_gray[%0d]", hl[j]), pix_b, exp_gray(hl[j]));
    end
  endtask

  task automatic do_line(input int v, input int fs, input bit ovr);
    int s0a, s0b;
    bit acc;
    s0a = n_start_a;
    s0b = n_start_b;
    do_req(v, fs, 1'b0, acc);
    if (acc) begin
      m_fetching = 1'b1;
      do_fetch(ovr, v + 1, $urandom_range(0, 3));
    end else begin
      repeat (4) @(negedge clk);
    end
    // Writes outside a fetch must not reach the line buffer
    for (int j = 0; j < 4; j++) begin
      disp_we = 1'b1; disp_waddr = 10'(j); disp_wdata = $urandom;
      @(negedge clk);
    end
    disp_we = 1'b0;
    check_eq("starts_a", 32'(n_start_a - s0a), acc ? 32'd1 : 32'd0);
    check_eq("starts_b", 32'(n_start_b - s0b), acc ? 32'd1 : 32'd0);
    if (ovr && acc) begin
      check_eq("ovr_held", overrun_a, m_overrun);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      m_overrun = 1'b0;
      check_eq("ovr_clr_a", overrun_a, m_overrun);
      check_eq("ovr_clr_b", overrun_b, m_overrun);
    end
    check_line();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int v, r;
    line_vpos = 11'd0; frame_sel = 2'd0; disp_waddr = 10'd0; disp_wdata = 32'd0; pix_hpos = 11'd0;
    do_reset();
    for (int i = 0; i < 4; i++) do_line(i, 0, 1'b0);
    do_line(0, 1, 1'b0);
    do_line(1, 0, 1'b0);
    do_line(0, 3, 1'b0);
    for (int i = 1; i < V_RES + 2; i++) do_line(i, 0, 1'b0);
    do_line(0, 0, 1'b1);
    do_line(2, 0, 1'b0);
    do_line(0, 0, 1'b0);
    do_line(1, 0, 1'b0);
    do_line(3, 0, 1'b0);
    do_line(5, 0, 1'b0);
    do_line(0, 0, 1'b0);
    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) v = m_exp;
      else if (r == 7) v = 0;
      else v = $urandom_range(0, 10);
      do_line(v, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
    end
    do_req(0, 0, 1'b0, acc);
    wait_start();
    @(negedge clk);
    do_reset();
    do_line(0, 0, 1'b0);
    do_line(1, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
